// File: rtl/battle_turn_ctrl.sv
// rtl/battle_turn_ctrl.sv - battle turn sequencer feeding game_engin
module battle_turn_ctrl #(
    parameter int         TURN_TIMEOUT  = 100,
    parameter int         AI_DELAY      = 4,
    parameter int         ATTACK_CYCLES = 1,
    parameter logic [7:0] LFSR_SEED     = 8'hA5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       collision_detected,
    input  logic [1:0] btn_choice,
    input  logic       btn_confirm,
    input  logic [4:0] enemy_remained_sword,
    input  logic [4:0] enemy_remained_baseballbat,
    input  logic       player_win,
    input  logic       enemy_win,
    output logic       player_turn,
    output logic       attacker_turn,
    output logic [1:0] player_choice,
    output logic [1:0] enemy_choice,
    output logic       in_battle,
    output logic       turn_timeout
);

    localparam int MAX_AB  = (AI_DELAY > ATTACK_CYCLES) ? AI_DELAY : ATTACK_CYCLES;
    localparam int MAX_ALL = (TURN_TIMEOUT > MAX_AB) ? TURN_TIMEOUT : MAX_AB;
    localparam int TW      = $clog2(MAX_ALL + 1);

    localparam logic [TW-1:0] TO_LAST  = TW'(TURN_TIMEOUT - 1);
    localparam logic [TW-1:0] AI_LAST  = TW'(AI_DELAY - 1);
    localparam logic [TW-1:0] ATK_LAST = TW'(ATTACK_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE, P_SELECT, P_ATTACK, P_CHECK, E_SELECT, E_ATTACK, E_CHECK, DONE
    } state_t;

    state_t        state, state_nxt;
    logic [TW-1:0] timer, timer_nxt;
    logic [1:0]    pc_nxt, ec_nxt;
    logic [1:0]    enemy_pick;
    logic [7:0]    lfsr;
    logic          col_q, conf_q;
    logic          col_rise, conf_rise;

    assign col_rise  = collision_detected & ~col_q;
    assign conf_rise = btn_confirm & ~conf_q;
    assign in_battle = (state != IDLE);

    // Enemy never picks "none"; exhausted weapons fall back to the fist.
    always_comb begin
        enemy_pick = (lfsr[1:0] == 2'b00) ? 2'b01 : lfsr[1:0];
        if (enemy_pick == 2'b11 && enemy_remained_sword == 5'd0)
            enemy_pick = 2'b01;
        if (enemy_pick == 2'b10 && enemy_remained_baseballbat == 5'd0)
            enemy_pick = 2'b01;
    end

    always_comb begin
        state_nxt     = state;
        timer_nxt     = timer + 1'b1;
        pc_nxt        = player_choice;
        ec_nxt        = enemy_choice;
        player_turn   = 1'b0;
        attacker_turn = 1'b0;
        turn_timeout  = 1'b0;
        case (state)
            IDLE: begin
                if (col_rise) begin
                    state_nxt = P_SELECT;
                    pc_nxt    = 2'b00;
                    ec_nxt    = 2'b00;
                end
            end
            P_SELECT: begin
                player_turn = 1'b1;
                // A valid confirm beats a simultaneous timeout.
                if (conf_rise && btn_choice != 2'b00) begin
                    pc_nxt    = btn_choice;
                    state_nxt = P_ATTACK;
                end else if (timer == TO_LAST) begin
                    pc_nxt       = 2'b01;
                    turn_timeout = 1'b1;
                    state_nxt    = P_ATTACK;
                end
            end
            P_ATTACK: begin
                player_turn   = 1'b1;
                attacker_turn = 1'b1;
                if (timer == ATK_LAST)
                    state_nxt = P_CHECK;
            end
            P_CHECK: begin
                player_turn = 1'b1;
                state_nxt   = (player_win || enemy_win) ? DONE : E_SELECT;
            end
            E_SELECT: begin
                if (timer == AI_LAST) begin
                    ec_nxt    = enemy_pick;
                    state_nxt = E_ATTACK;
                end
            end
            E_ATTACK: begin
                attacker_turn = 1'b1;
                if (timer == ATK_LAST)
                    state_nxt = E_CHECK;
            end
            E_CHECK: begin
                state_nxt = (player_win || enemy_win) ? DONE : P_SELECT;
            end
            DONE: begin
                if (!collision_detected)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (state_nxt != state || state == IDLE || state == DONE)
            timer_nxt = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            timer         <= '0;
            player_choice <= 2'b00;
            enemy_choice  <= 2'b00;
            lfsr          <= LFSR_SEED;
            col_q         <= 1'b0;
            conf_q        <= 1'b0;
        end else begin
            state         <= state_nxt;
            timer         <= timer_nxt;
            player_choice <= pc_nxt;
            enemy_choice  <= ec_nxt;
            lfsr          <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
            col_q         <= collision_detected;
            conf_q        <= btn_confirm;
        end
    end

endmodule

// File: tb/tb_battle_turn_ctrl.sv
// tb/tb_battle_turn_ctrl.sv - self-checking bench for battle_turn_ctrl
module tb_battle_turn_ctrl;

    localparam int         TO   = 8;
    localparam int         AD   = 4;
    localparam int         AC   = 1;
    localparam logic [7:0] SEED = 8'hA5;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       collision_detected = 1'b0;
    logic [1:0] btn_choice = 2'b00;
    logic       btn_confirm = 1'b0;
    logic [4:0] enemy_remained_sword = 5'd0;
    logic [4:0] enemy_remained_baseballbat = 5'd0;
    logic       player_win = 1'b0;
    logic       enemy_win = 1'b0;
    logic       player_turn, attacker_turn, in_battle, turn_timeout;
    logic [1:0] player_choice, enemy_choice;

    battle_turn_ctrl #(
        .TURN_TIMEOUT (TO),
        .AI_DELAY     (AD),
        .ATTACK_CYCLES(AC),
        .LFSR_SEED    (SEED)
    ) dut (
        .clk                       (clk),
        .rst_n                     (rst_n),
        .collision_detected        (collision_detected),
        .btn_choice                (btn_choice),
        .btn_confirm               (btn_confirm),
        .enemy_remained_sword      (enemy_remained_sword),
        .enemy_remained_baseballbat(enemy_remained_baseballbat),
        .player_win                (player_win),
        .enemy_win                 (enemy_win),
        .player_turn               (player_turn),
        .attacker_turn             (attacker_turn),
        .player_choice             (player_choice),
        .enemy_choice              (enemy_choice),
        .in_battle                 (in_battle),
        .turn_timeout              (turn_timeout)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // {player_turn, attacker_turn, player_choice, enemy_choice, in_battle, turn_timeout}
    function automatic logic [7:0] dut_vec();
        return {player_turn, attacker_turn, player_choice, enemy_choice, in_battle, turn_timeout};
    endfunction

    typedef struct {
        logic       col;
        logic [1:0] btn;
        logic       conf;
        logic       pwin;
        logic       ewin;
        logic [7:0] exp;
    } vec_t;
    vec_t tbl[$];

    task automatic add(input logic col, input logic [1:0] btn, input logic conf,
                       input logic pwin, input logic ewin, input logic [7:0] exp);
        vec_t v;
        v.col = col; v.btn = btn; v.conf = conf; v.pwin = pwin; v.ewin = ewin; v.exp = exp;
        tbl.push_back(v);
    endtask

    // Reference model: battle phase plus cycles spent in it.
    localparam int PH_IDLE = 0, PH_PSEL = 1, PH_PATK = 2, PH_PCHK = 3;
    localparam int PH_ESEL = 4, PH_EATK = 5, PH_ECHK = 6, PH_DONE = 7;

    int         m_ph;
    int         m_cnt;
    logic [7:0] m_lfsr;
    logic       m_colq, m_confq;
    logic [1:0] m_pc, m_ec;
    int         cov_s0 = 0, cov_s5 = 0;

    task automatic model_reset();
        m_ph = PH_IDLE; m_cnt = 0; m_lfsr = SEED;
        m_colq = 1'b0; m_confq = 1'b0; m_pc = 2'b00; m_ec = 2'b00;
    endtask

    function automatic logic model_valid_confirm();
        return btn_confirm && !m_confq && btn_choice != 2'b00;
    endfunction

    function automatic logic [7:0] model_outs();
        logic pt, at, ib, tmo;
        pt  = (m_ph == PH_PSEL || m_ph == PH_PATK || m_ph == PH_PCHK);
        at  = (m_ph == PH_PATK || m_ph == PH_EATK);
        ib  = (m_ph != PH_IDLE);
        tmo = (m_ph == PH_PSEL && m_cnt == TO - 1 && !model_valid_confirm());
        return {pt, at, m_pc, m_ec, ib, tmo};
    endfunction

    task automatic model_step();
        logic       win;
        logic [1:0] c;
        win = player_win || enemy_win;
        case (m_ph)
            PH_IDLE: if (collision_detected && !m_colq) begin
                m_ph = PH_PSEL; m_cnt = 0; m_pc = 2'b00; m_ec = 2'b00;
            end
            PH_PSEL: begin
                if (model_valid_confirm()) begin
                    m_pc = btn_choice; m_ph = PH_PATK; m_cnt = 0;
                end else if (m_cnt == TO - 1) begin
                    m_pc = 2'b01; m_ph = PH_PATK; m_cnt = 0;
                end else m_cnt++;
            end
            PH_PATK: if (m_cnt == AC - 1) begin m_ph = PH_PCHK; m_cnt = 0; end else m_cnt++;
            PH_PCHK: begin m_ph = win ? PH_DONE : PH_ESEL; m_cnt = 0; end
            PH_ESEL: begin
                if (m_cnt == AD - 1) begin
                    c = m_lfsr[1:0];
                    if (c == 2'b11 && enemy_remained_sword == 0) cov_s0++;
                    if (c == 2'b11 && enemy_remained_sword != 0) cov_s5++;
                    if (c == 2'b00) c = 2'b01;
                    if (c == 2'b11 && enemy_remained_sword == 0) c = 2'b01;
                    if (c == 2'b10 && enemy_remained_baseballbat == 0) c = 2'b01;
                    m_ec = c; m_ph = PH_EATK; m_cnt = 0;
                end else m_cnt++;
            end
            PH_EATK: if (m_cnt == AC - 1) begin m_ph = PH_ECHK; m_cnt = 0; end else m_cnt++;
            PH_ECHK: begin m_ph = win ? PH_DONE : PH_PSEL; m_cnt = 0; end
            default: if (!collision_detected) m_ph = PH_IDLE;
        endcase
        m_lfsr  = {m_lfsr[6:0], ^(m_lfsr & 8'hB8)};
        m_colq  = collision_detected;
        m_confq = btn_confirm;
    endtask

    // Inputs are set 1 time unit after the rising edge; compare on the falling edge.
    task automatic cycle_model();
        #4;
        check("model_outs", {24'd0, dut_vec()}, {24'd0, model_outs()});
        if (rst_n) model_step(); else model_reset();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; collision_detected = 1'b0; btn_choice = 2'b00; btn_confirm = 1'b0;
        player_win = 1'b0; enemy_win = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    int pulses, pulse_k;
    logic [1:0] pc_after;

    initial begin
        // Table: confirm flow, ignored confirms, win in P_CHECK, confirm vs timeout tie.
        add(0, 2'b00, 0, 0, 0, 8'h00);
        add(1, 2'b00, 0, 0, 0, 8'h00);
        add(1, 2'b00, 0, 0, 0, 8'h82);
        add(1, 2'b00, 1, 0, 0, 8'h82);
        add(1, 2'b11, 0, 0, 0, 8'h82);
        add(1, 2'b11, 1, 0, 0, 8'h82);
        add(1, 2'b11, 0, 0, 0, 8'hF2);
        add(1, 2'b00, 0, 1, 0, 8'hB2);
        add(1, 2'b00, 0, 1, 0, 8'h32);
        add(0, 2'b00, 0, 0, 0, 8'h32);
        add(0, 2'b00, 0, 0, 0, 8'h30);
        add(1, 2'b00, 0, 0, 0, 8'h30);
        add(1, 2'b00, 0, 0, 0, 8'h82);
        add(1, 2'b00, 0, 1, 1, 8'h82);
        for (int i = 0; i < 5; i++) add(0, 2'b00, 0, 0, 0, 8'h82);
        add(0, 2'b10, 1, 0, 0, 8'h82);
        add(0, 2'b10, 0, 0, 0, 8'hE2);
        add(0, 2'b10, 0, 0, 0, 8'hA2);
        add(0, 2'b00, 0, 1, 1, 8'h22);
        for (int i = 0; i < 3; i++) add(0, 2'b00, 0, 0, 0, 8'h22);

        #1;
        check("reset_outs", {24'd0, dut_vec()}, 32'd0);
        do_reset();
        for (int i = 0; i < tbl.size(); i++) begin
            collision_detected = tbl[i].col;
            btn_choice         = tbl[i].btn;
            btn_confirm        = tbl[i].conf;
            player_win         = tbl[i].pwin;
            enemy_win          = tbl[i].ewin;
            #4;
            check($sformatf("vec[%0d]", i), {24'd0, dut_vec()}, {24'd0, tbl[i].exp});
            @(posedge clk); #1;
        end

        // Timeout: no confirm, pulse on the 8th P_SELECT cycle, fist latched.
        do_reset();
        collision_detected = 1'b1;
        pulses = 0; pulse_k = -1; pc_after = 2'b00;
        for (int k = 0; k < 20; k++) begin
            #4;
            if (turn_timeout) begin pulses++; if (pulse_k < 0) pulse_k = k; end
            if (k == 9) pc_after = player_choice;
            @(posedge clk); #1;
        end
        check("timeout_pulses", pulses, 1);
        check("timeout_cycle", pulse_k, 8);
        check("timeout_choice", {30'd0, pc_after}, 32'd1);

        // Asynchronous reset while attacker_turn is high.
        do_reset();
        collision_detected = 1'b1;
        @(posedge clk); #1;
        btn_choice = 2'b11; btn_confirm = 1'b1;
        @(posedge clk); #1;
        #1;
        check("attack_before_reset", {31'd0, attacker_turn}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("async_reset_outs", {24'd0, dut_vec()}, 32'd0);
        do_reset();

        // Random lockstep against the reference model.
        model_reset();
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 499) == 0) begin
                rst_n = 1'b0;
                model_reset();
            end else rst_n = 1'b1;
            if ($urandom_range(0, 9) == 0) collision_detected = ~collision_detected;
            btn_choice  = 2'($urandom_range(0, 3));
            btn_confirm = ($urandom_range(0, 3) == 0);
            player_win  = ($urandom_range(0, 5) == 0);
            enemy_win   = ($urandom_range(0, 5) == 0);
            enemy_remained_sword       = ($urandom_range(0, 2) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            enemy_remained_baseballbat = ($urandom_range(0, 2) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            cycle_model();
        end
        check("cov_sword_empty", {31'd0, cov_s0 > 0}, 32'd1);
        check("cov_sword_avail", {31'd0, cov_s5 > 0}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
